req_enc32to5: RTL

- Sequential 32-to-5 request encoder; the inverse of the team's 5-to-32 enable decoder.
- Collects one-hot or multi-hot request lines (e.g. per-register or per-source strobes) into a sticky pending vector.
- Arbitrates the pending bits round-robin and presents one 5-bit index at a time over a valid/ready handshake, e.g. to a writeback or interrupt-service stage.

---
 rtl/req_enc32to5_pkg.sv | 17 +
 rtl/req_enc32to5_if.sv | 33 +++
 rtl/req_enc32to5_rr_pick.sv | 32 +++
 rtl/req_enc32to5.sv | 78 +++++++
 4 files changed

// File: rtl/req_enc32to5_pkg.sv
// Shared constants and helpers for the 32-to-5 request encoder.
// Optional feature macro: REQ_ENC_FIXED_PRIO_EN (selects fixed priority
// instead of round-robin; see req_enc32to5.sv).
package req_enc32to5_pkg;

  localparam int N    = 32;
  localparam int AW   = 5;
  localparam int WRAP = N - 1;

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] idx);
    logic [N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/req_enc32to5_if.sv
// Request/index handshake bundle between the request sources, the encoder
// and the consuming stage.
interface req_enc32to5_if;
  import req_enc32to5_pkg::*;

  logic          en;
  logic [N-1:0]  req_i;
  logic          ready_i;
  logic [AW-1:0] idx_o;
  logic          valid_o;
  logic [N-1:0]  pend_o;

  // Driver/consumer side.
  modport master (
    output en,
    output req_i,
    output ready_i,
    input  idx_o,
    input  valid_o,
    input  pend_o
  );

  // Encoder side.
  modport slave (
    input  en,
    input  req_i,
    input  ready_i,
    output idx_o,
    output valid_o,
    output pend_o
  );

endinterface

// File: rtl/req_enc32to5_rr_pick.sv
// Combinational round-robin picker: first set bit of cand at or above ptr,
// wrapping from bit 31 back to bit 0.
module req_enc32to5_rr_pick
  import req_enc32to5_pkg::*;
(
  input  logic [N-1:0]  cand,
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] sel,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [AW-1:0]  off;

  // Rotate right by ptr so the search always starts at bit 0 of rot.
  always_comb begin
    dbl = {cand, cand} >> ptr;
    rot = dbl[N-1:0];
  end

  // Lowest set bit of the rotated vector; mapping back is a mod-N add.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = AW'(i);
    end
    any = |cand;
    sel = off + ptr;
  end

endmodule

// File: rtl/req_enc32to5.sv
// Sequential 32-to-5 request encoder: sticky pending vector, round-robin
// arbitration and a valid/ready index output.
// Macro REQ_ENC_FIXED_PRIO_EN: lowest pending bit always wins, no pointer.
module req_enc32to5
  import req_enc32to5_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  req_enc32to5_if.slave     bus
);

  logic [N-1:0]  pend_q;
  logic [AW-1:0] idx_q;
  logic          valid_q;

  logic          hs;
  logic          load;
  logic          any;
  logic [N-1:0]  clr;
  logic [N-1:0]  cand;
  logic [AW-1:0] sel;
  logic [AW-1:0] ptr_use;

`ifdef REQ_ENC_FIXED_PRIO_EN
  assign ptr_use = '0;
`else
  logic [AW-1:0] ptr_q;

  assign ptr_use = ptr_q;

  // Rotate priority to just past the index most recently loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= (sel == AW'(WRAP)) ? '0 : sel + AW'(1);
    end
  end
`endif

  // Handshake, clear mask and candidate set; the in-flight index is masked
  // so it cannot be picked again while it is still being presented.
  always_comb begin
    hs   = valid_q & bus.ready_i;
    clr  = hs ? onehot(idx_q) : '0;
    cand = pend_q & ~(valid_q ? onehot(idx_q) : '0);
    load = bus.en & (~valid_q | hs) & any;
  end

  req_enc32to5_rr_pick u_pick (
    .cand (cand),
    .ptr  (ptr_use),
    .sel  (sel),
    .any  (any)
  );

  // Pending capture (set beats clear) and output index/valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~clr) | bus.req_i;
      if (load) begin
        idx_q   <= sel;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.idx_o   = idx_q;
  assign bus.valid_o = valid_q;
  assign bus.pend_o  = pend_q;

endmodule
